rs_issue_sched: RTL

Issue scheduler for one reservation-station bank (ALU, LSU or MUL). Chooses the entry slot for each newly dispatched instruction and tracks the relative age of occupied entries. It then selects the oldest operand-ready entry and hands its index to the functional unit over a valid/ready handshake. Sits between decode/rename dispatch, the bank's `rs_entry` array and the FU. One instance per bank.

---
 rtl/rs_pkg.sv | 35 +++
 rtl/rs_age_matrix.sv | 49 ++++
 rtl/rs_issue_sched.sv | 85 ++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station bank schedulers:
// bank size, index width and the small one-hot/priority helpers.
package rs_pkg;

  localparam int RS_SIZE = 4;
  localparam int IDX_W   = $clog2(RS_SIZE);

  typedef logic [RS_SIZE-1:0] rs_mask_t;
  typedef logic [IDX_W-1:0]   rs_idx_t;

  // Binary index of a one-hot vector; an all-zero vector yields 0.
  function automatic rs_idx_t onehot_to_idx(input rs_mask_t sel);
    rs_idx_t idx;
    idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (sel[i]) begin
        idx = idx | rs_idx_t'(i);
      end
    end
    return idx;
  endfunction

  // One-hot of the lowest set bit of vec (all zero when vec is zero).
  function automatic rs_mask_t lowest_set(input rs_mask_t vec);
    rs_mask_t sel;
    sel = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) begin
        sel = rs_mask_t'(1) << i;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Relative-age tracker for one bank: older[i][j] set means entry i was
// allocated before entry j. Picks the single oldest member of a mask.
module rs_age_matrix
  import rs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_en,
  input  logic [RS_SIZE-1:0] alloc_sel,
  input  logic [RS_SIZE-1:0] mask,
  output logic [RS_SIZE-1:0] pick_sel,
  output logic               pick_valid
);

  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_reg;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] col;

  // The new entry becomes younger than everyone; untouched pairs keep their order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_reg <= '0;
    end else if (alloc_en) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        for (int j = 0; j < RS_SIZE; j++) begin
          if (i != j) begin
            if (alloc_sel[i]) begin
              older_reg[i][j] <= 1'b0;
            end else if (alloc_sel[j]) begin
              older_reg[i][j] <= 1'b1;
            end
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_pick
      for (genvar gj = 0; gj < RS_SIZE; gj++) begin : g_col
        assign col[gi][gj] = older_reg[gj][gi];
      end
      // An entry wins when no other masked entry is older than it.
      assign pick_sel[gi] = mask[gi] & ~|(mask & col[gi]);
    end
  endgenerate

  assign pick_valid = |mask;

endmodule

// File: rtl/rs_issue_sched.sv
// Issue scheduler for one reservation-station bank: lowest-free allocation,
// oldest-ready selection and a single registered issue slot toward the FU.
module rs_issue_sched
  import rs_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               alloc_req_i,
  input  logic [RS_SIZE-1:0] entry_free_i,
  input  logic [RS_SIZE-1:0] entry_ready_i,
  input  logic               fu_ready_i,
  input  logic               flush_i,
  output logic               full_o,
  output logic               alloc_grant_o,
  output logic [RS_SIZE-1:0] alloc_sel_o,
  output logic [IDX_W-1:0]   alloc_idx_o,
  output logic               issue_valid_o,
  output logic [IDX_W-1:0]   issue_idx_o,
  output logic [RS_SIZE-1:0] issue_sel_o
);

  logic [RS_SIZE-1:0] cand;
  logic [RS_SIZE-1:0] pick_sel;
  logic               pick_valid;
  logic               load;
  logic               accept;
  logic               issue_valid_reg;
  logic               issue_valid_next;
  rs_idx_t            issue_idx_reg;
  rs_idx_t            issue_idx_next;

  assign full_o        = ~|entry_free_i;
  assign alloc_grant_o = alloc_req_i & ~full_o;
  assign alloc_sel_o   = alloc_grant_o ? lowest_set(entry_free_i) : '0;
  assign alloc_idx_o   = onehot_to_idx(alloc_sel_o);

  // The entry already sitting in the issue slot must not be picked twice.
  generate
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_cand
      assign cand[gi] = entry_ready_i[gi] & ~entry_free_i[gi]
                      & ~(issue_valid_reg & (issue_idx_reg == IDX_W'(gi)));
      assign issue_sel_o[gi] = accept & (issue_idx_reg == IDX_W'(gi));
    end
  endgenerate

  rs_age_matrix u_age (
    .clk        (clk_i),
    .rst        (reset_i),
    .alloc_en   (alloc_grant_o),
    .alloc_sel  (alloc_sel_o),
    .mask       (cand),
    .pick_sel   (pick_sel),
    .pick_valid (pick_valid)
  );

  assign load   = pick_valid & (~issue_valid_reg | fu_ready_i) & ~flush_i;
  assign accept = issue_valid_reg & fu_ready_i & ~flush_i;

  always_comb begin
    issue_valid_next = issue_valid_reg;
    issue_idx_next   = issue_idx_reg;
    if (flush_i) begin
      issue_valid_next = 1'b0;
    end else if (load) begin
      issue_valid_next = 1'b1;
      issue_idx_next   = onehot_to_idx(pick_sel);
    end else if (accept) begin
      issue_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      issue_valid_reg <= 1'b0;
      issue_idx_reg   <= '0;
    end else begin
      issue_valid_reg <= issue_valid_next;
      issue_idx_reg   <= issue_idx_next;
    end
  end

  assign issue_valid_o = issue_valid_reg;
  assign issue_idx_o   = issue_idx_reg;

endmodule
